// File: rtl/ram_responder_if.sv
// Request/response bus between the LSU (master) and the RAM responder (slave).
interface ram_responder_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [3:0]        req_be;
  logic              resp_valid;
  logic [DATA_W-1:0] resp_rdata;
  logic              resp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/ram_responder.sv
// Single-port RAM responder with programmable wait states and a one-cycle completion pulse.
// Define RAM_RESP_BYTEMASK_EN for per-byte-lane writes (DATA_W must then be 32).
module ram_responder #(
  parameter int ADDR_W      = 9,
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 512,
  parameter int WAIT_CYCLES = 1
) (
  input logic           clock,
  input logic           reset,
  ram_responder_if.slave bus
);
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_WAIT   = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;
  localparam logic [1:0] ST_RESP   = 2'd3;

  localparam int            IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0]    WAIT_INIT = 4'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);

  logic [1:0]        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [3:0]        be_q, be_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              err_q, err_d;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [IDX_W-1:0]  idx;
  logic              in_range;
  logic              mem_wr;
  logic [DATA_W-1:0] cur_word;
  logic [DATA_W-1:0] new_word;

  assign idx      = addr_q[IDX_W-1:0];
  assign in_range = ({1'b0, addr_q} < DEPTH_C);
  assign cur_word = in_range ? mem[idx] : '0;

`ifdef RAM_RESP_BYTEMASK_EN
  always_comb begin
    new_word = cur_word;
    for (int unsigned b = 0; b < 4; b++) begin
      if (be_q[b]) new_word[8*b +: 8] = wdata_q[8*b +: 8];
    end
  end
`else
  logic unused_be;
  assign unused_be = ^be_q;
  assign new_word  = wdata_q;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    mem_wr  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          we_d    = bus.req_we;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          be_d    = bus.req_be;
          if (WAIT_CYCLES > 0) begin
            state_d = ST_WAIT;
            cnt_d   = WAIT_INIT;
          end else begin
            state_d = ST_ACCESS;
          end
        end
      end
      ST_WAIT: begin
        if (cnt_q == '0) state_d = ST_ACCESS;
        else             cnt_d   = cnt_q - 4'd1;
      end
      ST_ACCESS: begin
        // Out-of-range requests complete normally but return zero and flag an error.
        state_d = ST_RESP;
        err_d   = ~in_range;
        rdata_d = in_range ? (we_q ? new_word : cur_word) : '0;
        mem_wr  = we_q & in_range;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Array is never cleared; a reset in ACCESS suppresses the pending write.
  always_ff @(posedge clock) begin
    if (mem_wr && !reset) mem[idx] <= new_word;
  end

  assign bus.req_ready  = (state_q == ST_IDLE);
  assign bus.resp_valid = (state_q == ST_RESP);
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;
endmodule

// File: tb/tb_ram_responder.sv
// Scoreboard bench for ram_responder: three instances cover WAIT_CYCLES 1/0/3 and DEPTH 256/512.
module tb_ram_responder;
  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic rst0, rst1, rst2;
  int unsigned sel;
  logic        v, we;
  logic [8:0]  addr;
  logic [31:0] wdata;
  logic [3:0]  be;

  int unsigned n_cmp = 0;
  int unsigned n_fail = 0;
  int unsigned cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  ram_responder_if #(.ADDR_W(9), .DATA_W(32)) bus0 ();
  ram_responder_if #(.ADDR_W(9), .DATA_W(32)) bus1 ();
  ram_responder_if #(.ADDR_W(9), .DATA_W(32)) bus2 ();

  assign bus0.req_valid = v && (sel == 0);
  assign bus1.req_valid = v && (sel == 1);
  assign bus2.req_valid = v && (sel == 2);
  assign bus0.req_we = we;    assign bus1.req_we = we;    assign bus2.req_we = we;
  assign bus0.req_addr = addr; assign bus1.req_addr = addr; assign bus2.req_addr = addr;
  assign bus0.req_wdata = wdata; assign bus1.req_wdata = wdata; assign bus2.req_wdata = wdata;
  assign bus0.req_be = be;    assign bus1.req_be = be;    assign bus2.req_be = be;

  ram_responder #(.ADDR_W(9), .DATA_W(32), .DEPTH(256), .WAIT_CYCLES(1))
    dut0 (.clock(clock), .reset(rst0), .bus(bus0));
  ram_responder #(.ADDR_W(9), .DATA_W(32), .DEPTH(512), .WAIT_CYCLES(0))
    dut1 (.clock(clock), .reset(rst1), .bus(bus1));
  ram_responder #(.ADDR_W(9), .DATA_W(32), .DEPTH(512), .WAIT_CYCLES(3))
    dut2 (.clock(clock), .reset(rst2), .bus(bus2));

  logic [2:0]  rdy, rv, er;
  logic [31:0] rd [3];
  assign rdy = {bus2.req_ready, bus1.req_ready, bus0.req_ready};
  assign rv  = {bus2.resp_valid, bus1.resp_valid, bus0.resp_valid};
  assign er  = {bus2.resp_err, bus1.resp_err, bus0.resp_err};
  assign rd[0] = bus0.resp_rdata;
  assign rd[1] = bus1.resp_rdata;
  assign rd[2] = bus2.resp_rdata;

  typedef struct {
    int unsigned dut;
    logic [31:0] rdata;
    logic        chk_rdata;
    logic        err;
    int unsigned cyc;
    string       name;
  } exp_t;
  exp_t sb[$];

  function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endfunction

  // Monitor: every response pulse must match the oldest outstanding expectation.
  always @(negedge clock) begin : monitor
    exp_t e;
    for (int k = 0; k < 3; k++) begin
      if (rv[k]) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_resp dut%0d actual=resp_valid required=idle", k);
        end else begin
          e = sb.pop_front();
          chk({e.name, "_dut"}, k, e.dut);
          chk({e.name, "_cycle"}, cyc, e.cyc);
          chk({e.name, "_err"}, {31'b0, er[k]}, {31'b0, e.err});
          if (e.chk_rdata) chk({e.name, "_rdata"}, rd[k], e.rdata);
        end
      end
    end
  end

  task automatic issue(input int unsigned d, input logic w, input logic [8:0] a,
                       input logic [31:0] wd, input logic [3:0] b,
                       input logic [31:0] er_data, input logic ckr, input logic ee,
                       input string nm, input bit expect_resp, input bit hold,
                       input int unsigned wc, output int unsigned acc_cyc);
    int unsigned guard;
    sel = d; we = w; addr = a; wdata = wd; be = b; v = 1'b1;
    guard = 0;
    acc_cyc = 0;
    while (!rdy[d] && guard < 50) begin
      @(posedge clock); @(negedge clock);
      guard++;
    end
    if (!rdy[d]) begin
      chk({nm, "_accept_timeout"}, 0, 1);
      v = 1'b0;
      return;
    end
    acc_cyc = cyc + 1;
    if (expect_resp) sb.push_back('{d, er_data, ckr, ee, acc_cyc + wc + 1, nm});
    @(posedge clock); @(negedge clock);
    chk({nm, "_ready_low"}, {31'b0, rdy[d]}, 0);
    if (!hold) begin
      v = 1'b0; we = ~w; addr = ~a; wdata = ~wd; be = ~b;
    end
  endtask

  task automatic drain(input string nm);
    int unsigned g;
    g = 0;
    while (sb.size() != 0 && g < 100) begin
      @(negedge clock);
      g++;
    end
    if (sb.size() != 0) begin
      chk({nm, "_drain_timeout"}, sb.size(), 0);
      sb.delete();
    end
    repeat (2) @(negedge clock);
  endtask

  task automatic chk_reset(input int unsigned d, input string nm);
    chk({nm, "_ready"}, {31'b0, rdy[d]}, 1);
    chk({nm, "_valid"}, {31'b0, rv[d]}, 0);
    chk({nm, "_rdata"}, rd[d], 0);
    chk({nm, "_err"}, {31'b0, er[d]}, 0);
  endtask

  logic [31:0] m1, m2;
  int unsigned ac, ac1, ac2;

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
`ifdef RAM_RESP_BYTEMASK_EN
    m1 = 32'h11BB33DD;
    m2 = 32'h11BB33DD;
`else
    m1 = 32'hAABBCCDD;
    m2 = 32'h55555555;
`endif
    v = 1'b0; sel = 0; we = 1'b0; addr = '0; wdata = '0; be = '0;
    rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk_reset(0, "rst_d0");
    chk_reset(1, "rst_d1");
    chk_reset(2, "rst_d2");
    rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;
    @(negedge clock);

    // Test 1/2: WAIT_CYCLES=1
    issue(0, 1, 9'h010, 32'hDEADBEEF, 4'hF, 32'hDEADBEEF, 1, 0, "t1_wr", 1, 0, 1, ac);
    drain("t1");
    issue(0, 0, 9'h010, 32'h0, 4'hF, 32'hDEADBEEF, 1, 0, "t2_rd10", 1, 0, 1, ac);
    issue(0, 1, 9'h011, 32'h00000005, 4'hF, 32'h00000005, 1, 0, "t2_wr11", 1, 0, 1, ac);
    issue(0, 0, 9'h011, 32'h0, 4'hF, 32'h00000005, 1, 0, "t2_rd11", 1, 0, 1, ac);
    drain("t2");
    chk("t2_rdata_held", rd[0], 32'h00000005);

    // Test 4: DEPTH=256 out-of-range handling
    issue(0, 1, 9'h000, 32'h0000A5A5, 4'hF, 32'h0000A5A5, 1, 0, "t4_wr0", 1, 0, 1, ac);
    issue(0, 1, 9'h100, 32'h12345678, 4'hF, 32'h0, 0, 1, "t4_wr100", 1, 0, 1, ac);
    issue(0, 0, 9'h1FF, 32'h0, 4'hF, 32'h0, 1, 1, "t4_rd1ff", 1, 0, 1, ac);
    drain("t4a");
    chk("t4_err_held", {31'b0, er[0]}, 1);
    issue(0, 0, 9'h000, 32'h0, 4'hF, 32'h0000A5A5, 1, 0, "t4_rd0", 1, 0, 1, ac);
    drain("t4b");

    // Test 6: byte-lane writes (or full-word writes without the macro)
    issue(0, 1, 9'h030, 32'h11223344, 4'hF, 32'h11223344, 1, 0, "t6_init", 1, 0, 1, ac);
    issue(0, 1, 9'h030, 32'hAABBCCDD, 4'b0101, m1, 1, 0, "t6_wr0101", 1, 0, 1, ac);
    issue(0, 0, 9'h030, 32'h0, 4'hF, m1, 1, 0, "t6_rd1", 1, 0, 1, ac);
    issue(0, 1, 9'h030, 32'h55555555, 4'b0000, m2, 1, 0, "t6_wr0000", 1, 0, 1, ac);
    issue(0, 0, 9'h030, 32'h0, 4'hF, m2, 1, 0, "t6_rd2", 1, 0, 1, ac);
    drain("t6");

    // Test 3: WAIT_CYCLES=0, req_valid held across two reads
    issue(1, 1, 9'h010, 32'h01010101, 4'hF, 32'h01010101, 1, 0, "t3_wr10", 1, 0, 0, ac);
    issue(1, 1, 9'h011, 32'h02020202, 4'hF, 32'h02020202, 1, 0, "t3_wr11", 1, 0, 0, ac);
    drain("t3a");
    issue(1, 0, 9'h010, 32'h0, 4'hF, 32'h01010101, 1, 0, "t3_rd10", 1, 1, 0, ac1);
    issue(1, 0, 9'h011, 32'h0, 4'hF, 32'h02020202, 1, 0, "t3_rd11", 1, 0, 0, ac2);
    chk("t3_spacing", ac2 - ac1, 3);
    drain("t3b");

    // Test 5: WAIT_CYCLES=3, reset aborts in WAIT and in ACCESS
    issue(2, 1, 9'h020, 32'h0BADF00D, 4'hF, 32'h0BADF00D, 1, 0, "t5_init", 1, 0, 3, ac);
    drain("t5a");
    issue(2, 1, 9'h020, 32'hCAFEF00D, 4'hF, 32'h0, 0, 0, "t5_abort_wait", 0, 0, 3, ac);
    @(posedge clock); @(negedge clock);
    rst2 = 1'b1;
    @(posedge clock); @(negedge clock);
    rst2 = 1'b0;
    chk_reset(2, "t5_wait_rst");
    drain("t5b");
    issue(2, 0, 9'h020, 32'h0, 4'hF, 32'h0BADF00D, 1, 0, "t5_rd1", 1, 0, 3, ac);
    drain("t5c");
    issue(2, 1, 9'h020, 32'hCAFEF00D, 4'hF, 32'h0, 0, 0, "t5_abort_acc", 0, 0, 3, ac);
    repeat (3) begin
      @(posedge clock); @(negedge clock);
    end
    rst2 = 1'b1;
    @(posedge clock); @(negedge clock);
    rst2 = 1'b0;
    chk_reset(2, "t5_acc_rst");
    drain("t5d");
    issue(2, 0, 9'h020, 32'h0, 4'hF, 32'h0BADF00D, 1, 0, "t5_rd2", 1, 0, 3, ac);
    drain("t5e");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
